// File: rtl/adc_dac_loop_sequencer_if.sv
// ADC-reader / DAC-driver handshake bundle seen by the loop sequencer.
// The slave side is the sequencer; the master side is the reader/driver pair.
interface adc_dac_loop_sequencer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  adc_new_data;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  dac_start;
  logic [DATA_WIDTH-1:0] dac_data;
  logic                  dac_busy;

  modport slave  (input  adc_new_data, adc_data, dac_busy,
                  output dac_start, dac_data);
  modport master (output adc_new_data, adc_data, dac_busy,
                  input  dac_start, dac_data);
endinterface

// File: rtl/adc_dac_loop_sequencer.sv
// ADC-to-DAC feedback loop sequencer: decimates reader samples, issues one DAC
// write at a time, counts forwarded/dropped samples and owns the reader gain.
module adc_dac_loop_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [7:0]            decim,
  input  logic                  gain_wr,
  input  logic [GAIN_WIDTH-1:0] gain_in,
  output logic                  gain_pending,
  output logic [GAIN_WIDTH-1:0] GAIN,
  output logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic [CNT_WIDTH-1:0]  overrun_cnt,
  output logic                  active,
  adc_dac_loop_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_BUSY, WRITING} state_t;

  localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = GAIN_WIDTH'(16'h0100);

  state_t                state_q, state_d;
  logic [7:0]            decim_q, decim_d;
  logic [7:0]            dcnt_q, dcnt_d;
  logic [1:0]            wait_q, wait_d;
  logic                  dac_start_q;
  logic [DATA_WIDTH-1:0] dac_data_q;
  logic [GAIN_WIDTH-1:0] gain_q, shadow_q;
  logic                  pending_q;
  logic [CNT_WIDTH-1:0]  smp_q, ovr_q;
  logic                  fwd, drop, boundary;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      decim_q <= '0;
      dcnt_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    wait_d  = wait_q;
    fwd     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        decim_d = decim;
        dcnt_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = IDLE;
        else if (bus.adc_new_data) begin
          if (dcnt_q == '0) begin
            dcnt_d  = decim_q;
            fwd     = 1'b1;
            wait_d  = '0;
            state_d = WAIT_BUSY;
          end else dcnt_d = dcnt_q - 8'd1;
        end
      end
      // busy is ignored in the dac_start cycle itself: the driver cannot have
      // reacted yet, and this keeps successive starts at least 4 cycles apart.
      WAIT_BUSY: begin
        if ((wait_q != 2'd0 && bus.dac_busy) || wait_q == 2'd2) state_d = WRITING;
        else wait_d = wait_q + 2'd1;
      end
      WRITING: if (!bus.dac_busy) state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == WAIT_BUSY || state_q == WRITING) && bus.adc_new_data) begin
      if (dcnt_q == '0) begin
        drop   = 1'b1;
        dcnt_d = decim_q;
      end else dcnt_d = dcnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dac_start_q <= 1'b0;
      dac_data_q  <= '0;
      smp_q       <= '0;
      ovr_q       <= '0;
    end else begin
      dac_start_q <= fwd;
      if (fwd) dac_data_q <= bus.adc_data;
      if (fwd && smp_q != '1) smp_q <= smp_q + 1'b1;
      if (drop && ovr_q != '1) ovr_q <= ovr_q + 1'b1;
    end
  end

  // On a boundary GAIN takes the old shadow; a same-cycle write lands in the
  // shadow and stays pending for the following boundary.
  assign boundary = bus.adc_new_data || (state_q == IDLE);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      gain_q    <= GAIN_UNITY;
      shadow_q  <= GAIN_UNITY;
      pending_q <= 1'b0;
    end else begin
      if (boundary) gain_q <= shadow_q;
      if (gain_wr) begin
        shadow_q  <= gain_in;
        pending_q <= 1'b1;
      end else if (boundary) pending_q <= 1'b0;
    end
  end

  assign bus.dac_start = dac_start_q;
  assign bus.dac_data  = dac_data_q;
  assign GAIN          = gain_q;
  assign gain_pending  = pending_q;
  assign sample_cnt    = smp_q;
  assign overrun_cnt   = ovr_q;
  assign active        = (state_q != IDLE);

endmodule

// File: tb/tb_adc_dac_loop_sequencer.sv
// Directed bench: table of decimation/overrun scenarios plus hand sequences
// for latency, gain boundaries, enable drop and mid-write reset.
module tb_adc_dac_loop_sequencer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  decim = '0;
  logic        gain_wr = 1'b0;
  logic [15:0] gain_in = '0;
  logic        gain_pending;
  logic [15:0] GAIN;
  logic [15:0] sample_cnt, overrun_cnt;
  logic        active;

  adc_dac_loop_sequencer_if #(.DATA_WIDTH(16)) bus ();

  adc_dac_loop_sequencer dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .decim(decim),
    .gain_wr(gain_wr), .gain_in(gain_in), .gain_pending(gain_pending),
    .GAIN(GAIN), .sample_cnt(sample_cnt), .overrun_cnt(overrun_cnt),
    .active(active), .bus(bus)
  );

  always #5 clk = ~clk;

  // DAC driver model: busy for busy_len cycles, starting the edge after dac_start
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) busy_cnt <= 0;
    else if (bus.dac_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.dac_busy = (busy_cnt != 0);

  // Observers: start count, start spacing, data stability while busy
  int cyc = 0, starts = 0, last_start = -100, spacing_err = 0, stab_err = 0;
  logic [15:0] prev_data = '0;
  always @(negedge clk) begin
    if (!aresetn) begin
      last_start  = -100;
      spacing_err = 0;
      stab_err    = 0;
    end else begin
      if (bus.dac_start) begin
        starts++;
        if (cyc - last_start < 4) spacing_err++;
        last_start = cyc;
      end
      if (bus.dac_busy && bus.dac_data !== prev_data) stab_err++;
    end
    prev_data = bus.dac_data;
    cyc++;
  end

  int n_vec = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v);
    bus.adc_new_data = 1'b1;
    bus.adc_data     = v;
    tick();
    bus.adc_new_data = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    enable  = 1'b0;
    gain_wr = 1'b0;
    bus.adc_new_data = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 aresetn = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [7:0]  decim;
    int          npulse;
    int          spacing;
    int          busy;
    logic [15:0] base;
    int          exp_smp;
    int          exp_ovr;
    logic [15:0] exp_data;
  } scn_t;

  scn_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    bus.adc_new_data = 1'b0;
    bus.adc_data     = '0;

    tbl[0] = '{8'd0, 10, 10, 25, 16'h1000, 4, 6, 16'h1009};
    tbl[1] = '{8'd3, 12, 40, 20, 16'h2000, 3, 0, 16'h2008};
    tbl[2] = '{8'd1,  8, 10, 25, 16'h3000, 2, 2, 16'h3004};
    tbl[3] = '{8'd0,  6,  5,  0, 16'h4000, 6, 0, 16'h4005};
    tbl[4] = '{8'd0,  6,  4,  0, 16'h5000, 3, 3, 16'h5004};
    tbl[5] = '{8'd0,  5,  4,  1, 16'h6000, 5, 0, 16'h6004};

    // reset values and first-sample latency
    do_reset();
    check("rst_gain", GAIN, 32'h0100);
    check("rst_pending", gain_pending, 0);
    check("rst_start", bus.dac_start, 0);
    check("rst_data", bus.dac_data, 0);
    check("rst_smp", sample_cnt, 0);
    check("rst_ovr", overrun_cnt, 0);
    check("rst_active", active, 0);
    busy_len = 20; decim = 8'd0; enable = 1'b1;
    tick(); tick();
    check("run_active", active, 1);
    check("pre_start", bus.dac_start, 0);
    pulse(16'h1234);
    check("lat_start", bus.dac_start, 1);
    check("lat_data", bus.dac_data, 32'h1234);
    check("lat_smp", sample_cnt, 1);
    check("lat_gain", GAIN, 32'h0100);
    tick();
    check("start_1cyc", bus.dac_start, 0);

    // gain updates at sample boundaries
    gain_wr = 1'b1; gain_in = 16'h0200; tick(); gain_wr = 1'b0;
    check("g_pend", gain_pending, 1);
    check("g_hold0", GAIN, 32'h0100);
    repeat (3) tick();
    check("g_hold1", GAIN, 32'h0100);
    pulse(16'h0001);
    check("g_apply", GAIN, 32'h0200);
    check("g_clear", gain_pending, 0);
    gain_wr = 1'b1; gain_in = 16'h0300; pulse(16'h0002); gain_wr = 1'b0;
    check("g_same_gain", GAIN, 32'h0200);
    check("g_same_pend", gain_pending, 1);
    tick();
    check("g_same_hold", GAIN, 32'h0200);
    pulse(16'h0003);
    check("g_second", GAIN, 32'h0300);
    gain_wr = 1'b1; gain_in = 16'h0400; tick(); gain_in = 16'h0500; tick(); gain_wr = 1'b0;
    pulse(16'h0004);
    check("g_lastwins", GAIN, 32'h0500);
    enable = 1'b0;
    repeat (30) tick();
    check("g_idle", active, 0);
    gain_wr = 1'b1; gain_in = 16'h0600; tick(); gain_wr = 1'b0;
    check("g_idle_pend", gain_pending, 1);
    check("g_idle_hold", GAIN, 32'h0500);
    tick();
    check("g_idle_apply", GAIN, 32'h0600);
    check("g_idle_clr", gain_pending, 0);

    // decimation / overrun scenario table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      busy_len = tbl[i].busy; decim = tbl[i].decim; enable = 1'b1;
      tick(); tick();
      s0 = starts;
      for (int k = 0; k < tbl[i].npulse; k++) begin
        pulse(tbl[i].base + 16'(k));
        repeat (tbl[i].spacing - 1) tick();
      end
      repeat (tbl[i].busy + 10) tick();
      check($sformatf("scn%0d_smp", i), sample_cnt, tbl[i].exp_smp);
      check($sformatf("scn%0d_ovr", i), overrun_cnt, tbl[i].exp_ovr);
      check($sformatf("scn%0d_data", i), bus.dac_data, tbl[i].exp_data);
      check($sformatf("scn%0d_starts", i), starts - s0, tbl[i].exp_smp);
      check($sformatf("scn%0d_spacing", i), spacing_err, 0);
      check($sformatf("scn%0d_stable", i), stab_err, 0);
    end

    // enable dropped during a write: write finishes, then IDLE
    do_reset();
    busy_len = 20; decim = 8'd0; enable = 1'b1;
    tick(); tick();
    s0 = starts;
    pulse(16'hABCD);
    repeat (5) tick();
    enable = 1'b0;
    repeat (10) tick();
    check("en_write_active", active, 1);
    repeat (10) tick();
    check("en_idle", active, 0);
    for (int k = 0; k < 3; k++) begin
      pulse(16'h0F00 + 16'(k));
      repeat (4) tick();
    end
    check("en_starts", starts - s0, 1);
    check("en_smp", sample_cnt, 1);
    check("en_data", bus.dac_data, 32'hABCD);
    enable = 1'b1; tick();
    check("en_run", active, 1);
    enable = 1'b0; tick();
    check("en_run_drop", active, 0);

    // asynchronous reset in the middle of a write
    do_reset();
    busy_len = 20; decim = 8'd0; enable = 1'b1;
    tick(); tick();
    gain_wr = 1'b1; gain_in = 16'h0700; tick(); gain_wr = 1'b0;
    pulse(16'h5A5A);
    gain_wr = 1'b1; gain_in = 16'h0800; tick(); gain_wr = 1'b0;
    repeat (4) tick();
    check("ar_pre_gain", GAIN, 32'h0700);
    check("ar_pre_pend", gain_pending, 1);
    check("ar_pre_data", bus.dac_data, 32'h5A5A);
    #2 aresetn = 1'b0; enable = 1'b0;
    #1;
    check("ar_gain", GAIN, 32'h0100);
    check("ar_pend", gain_pending, 0);
    check("ar_start", bus.dac_start, 0);
    check("ar_data", bus.dac_data, 0);
    check("ar_smp", sample_cnt, 0);
    check("ar_ovr", overrun_cnt, 0);
    check("ar_active", active, 0);
    @(posedge clk);
    #1 aresetn = 1'b1;
    tick();
    check("ar_rel_gain", GAIN, 32'h0100);
    check("ar_rel_smp", sample_cnt, 0);
    check("ar_rel_ovr", overrun_cnt, 0);
    check("ar_rel_active", active, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_dac_loop_sequencer.md
# adc_dac_loop_sequencer

Sequences the ADC-to-DAC feedback loop. It sits between the AD4008 reader (which pulses `new_data_flag` with `amplified_data`) and the DAC8411 write driver (start/busy handshake), and owns the `GAIN` register feeding the reader. Gain updates are applied only at sample boundaries. Samples are decimated by a programmable ratio, DAC writes are issued one at a time, and dropped samples are counted.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: sample and DAC word width.
- `GAIN_WIDTH`, default 16: gain word width (8.8 fixed point in the reader).
- `CNT_WIDTH`, default 16: width of the status counters.

Ports:
- `clk` in 1: system clock, same clock as the ADC reader and DAC driver.
- `aresetn` in 1: asynchronous active-low reset.
- `enable` in 1: level; loop runs while high.
- `decim` in 8: forward one of every `decim+1` samples (0 = every sample); sampled only in IDLE.
- `gain_wr` in 1: single-cycle request to load `gain_in`.
- `gain_in` in GAIN_WIDTH: new gain value.
- `gain_pending` out 1: a written gain is waiting for the next sample boundary.
- `GAIN` out GAIN_WIDTH: active gain, to the ADC reader.
- `adc_new_data` in 1: single-cycle pulse from the reader.
- `adc_data` in DATA_WIDTH: reader's `amplified_data`, valid on the pulse cycle.
- `dac_start` out 1: single-cycle write request to the DAC driver.
- `dac_data` out DATA_WIDTH: word to write; held stable from `dac_start` until the next `dac_start`.
- `dac_busy` in 1: DAC driver busy; it rises no later than 2 cycles after `dac_start`.
- `sample_cnt` out CNT_WIDTH: samples forwarded to the DAC; saturating.
- `overrun_cnt` out CNT_WIDTH: samples selected for forwarding but dropped because a write was in progress; saturating.
- `active` out 1: high in any state other than IDLE.

## Operation
- Reset values: state IDLE; `GAIN` = 0x0100 (unity); `gain_pending` 0; `dac_start` 0; `dac_data` 0; both counters 0; `active` 0; decimation counter 0; shadow gain 0x0100.
- Gain path:
  - `gain_wr` loads the shadow register and sets `gain_pending`.
  - The shadow is copied to `GAIN`, and `gain_pending` cleared, on a cycle with `adc_new_data`=1, or on any cycle while in IDLE.
  - `gain_wr` on that same cycle wins: the new value goes to the shadow and `gain_pending` stays set.
  - Multiple writes before a boundary: the last value wins.
- States:
  - IDLE: when `enable`=1, latch `decim` into `decim_q`, load the decimation counter with 0, and go to RUN.
  - RUN: on `adc_new_data`:
    - If counter = 0: reload it with `decim_q`, capture `adc_data` into `dac_data`, pulse `dac_start`, increment `sample_cnt`, go to WAIT_BUSY.
    - Otherwise: decrement the counter and discard the sample.
  - WAIT_BUSY: wait for `dac_busy`=1, then go to WRITING. If `dac_busy` has not risen after 2 cycles, go to WRITING anyway (the DAC driver may have completed the write instantly).
  - WRITING: when `dac_busy`=0, go to RUN, or to IDLE if `enable`=0.
- Samples arriving in WAIT_BUSY or WRITING: the decimation counter still advances. A sample that would have been forwarded (counter = 0) is dropped, `overrun_cnt` increments, and the counter reloads.
- Deasserting `enable` in RUN goes to IDLE on the next cycle. Deasserting it in WAIT_BUSY or WRITING lets the write finish first; a write is never aborted.
- `dac_start` is never asserted outside the RUN→WAIT_BUSY transition.
- Counters saturate at all-ones; they clear only on reset.

## Timing
- Latency: `adc_new_data` at edge N gives `dac_start`=1 and `dac_data` valid in cycle N+1 (registered).
- Gain: the `GAIN` update is registered at the boundary edge, so the reader's next multiply uses the new gain.
- Minimum spacing between successive `dac_start` pulses: 4 cycles.
- Asynchronous reset mid-write forces all outputs to their reset values immediately. The DAC driver is reset by the same `aresetn`.
- `adc_new_data` and `gain_wr` in the same cycle are both honoured, per the gain rules above.

## Test plan
- Reset, then `enable`=1, `decim`=0, with `adc_data`=0x1234 on a pulse; DAC model holds busy for 20 cycles → one `dac_start` one cycle after the pulse, `dac_data`=0x1234, `sample_cnt`=1, `GAIN`=0x0100.
- `decim`=3, 12 ADC pulses spaced 40 cycles apart → forwarded pulses 1, 5 and 9, `sample_cnt`=3, `overrun_cnt`=0.
- `decim`=0, ADC pulses every 10 cycles, DAC busy for 25 cycles → pulses arriving during a write are dropped; after 10 pulses, `sample_cnt` + `overrun_cnt` = 10 with `overrun_cnt` > 0; `dac_data` never changes while `dac_busy`=1.
- `gain_wr` with 0x0200 in RUN → `gain_pending`=1 and `GAIN` holds 0x0100 until the next `adc_new_data`, then `GAIN`=0x0200. A second `gain_wr` with 0x0300 on the pulse cycle leaves `GAIN`=0x0200 and `gain_pending`=1.
- `enable` dropped in WRITING → the write completes, the FSM returns to IDLE and `active`=0; with `enable`=0 no further `dac_start` occurs.
- `aresetn` asserted in WRITING → all outputs return to reset values in the same cycle; after release, `GAIN`=0x0100 and both counters are 0.
